// File: rtl/hamming_scrub_decoder.sv
// Hamming(7,4)-per-nibble SEC checker/corrector for a 16-bit word with 12-bit parity.
// Two-stage valid/ready pipeline: syndromes, then corrected data with regenerated parity.
module hamming_scrub_decoder #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic [11:0]       in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [11:0]       out_parity,
  output logic [3:0]        out_err,
  output logic [11:0]       out_syn,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sticky,
  input  logic              clear
);

  localparam int SW = CNT_W + 3;

  // Returns {p4,p2,p1} for one data nibble.
  function automatic logic [2:0] enc(input logic [3:0] d);
    return {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic logic [3:0] flip_mask(input logic [2:0] s);
    case (s)
      3'd3:    return 4'b0001;
      3'd5:    return 4'b0010;
      3'd6:    return 4'b0100;
      3'd7:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  logic              s1_valid_reg;
  logic [15:0]       s1_data_reg;
  logic [11:0]       s1_syn_reg;
  logic              s2_valid_reg;
  logic [15:0]       out_data_reg;
  logic [11:0]       out_parity_reg;
  logic [3:0]        out_err_reg;
  logic [11:0]       out_syn_reg;
  logic [CNT_W-1:0]  err_count_reg;
  logic              err_sticky_reg;

  logic [11:0]       in_syn;
  logic [15:0]       corr_data;
  logic [11:0]       corr_parity;
  logic [3:0]        corr_err;

  logic              s2_adv;
  logic              out_fire;
  logic [2:0]        err_pop;
  logic [SW-1:0]     cnt_sum;
  logic [SW-1:0]     cnt_max;
  logic [CNT_W-1:0]  err_count_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign in_syn[3*gi +: 3]      = enc(in_data[4*gi +: 4]) ^ in_parity[3*gi +: 3];
      assign corr_data[4*gi +: 4]   = s1_data_reg[4*gi +: 4] ^ flip_mask(s1_syn_reg[3*gi +: 3]);
      assign corr_parity[3*gi +: 3] = enc(corr_data[4*gi +: 4]);
      assign corr_err[gi]           = |s1_syn_reg[3*gi +: 3];
    end
  endgenerate

  // Stage 2 can take a word when it is empty or its word leaves this cycle.
  assign s2_adv   = !s2_valid_reg | out_ready;
  assign in_ready = !s1_valid_reg | s2_adv;
  assign out_fire = s2_valid_reg & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_syn_reg   <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_data_reg <= in_data;
        s1_syn_reg  <= in_syn;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg   <= 1'b0;
      out_data_reg   <= '0;
      out_parity_reg <= '0;
      out_err_reg    <= '0;
      out_syn_reg    <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg   <= corr_data;
        out_parity_reg <= corr_parity;
        out_err_reg    <= corr_err;
        out_syn_reg    <= s1_syn_reg;
      end
    end
  end

  // Wide sum so adding up to four events never wraps before the saturation compare.
  always_comb begin
    err_pop = {2'b00, out_err_reg[0]} + {2'b00, out_err_reg[1]}
            + {2'b00, out_err_reg[2]} + {2'b00, out_err_reg[3]};
    cnt_sum = SW'(err_count_reg) + SW'(err_pop);
    cnt_max = SW'({CNT_W{1'b1}});
    err_count_next = (cnt_sum > cnt_max) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_reg  <= '0;
      err_sticky_reg <= 1'b0;
    end else if (clear) begin
      err_count_reg  <= '0;
      err_sticky_reg <= 1'b0;
    end else if (out_fire) begin
      err_count_reg  <= err_count_next;
      err_sticky_reg <= err_sticky_reg | (|out_err_reg);
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_data   = out_data_reg;
  assign out_parity = out_parity_reg;
  assign out_err    = out_err_reg;
  assign out_syn    = out_syn_reg;
  assign err_count  = err_count_reg;
  assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_hamming_scrub_decoder.sv
// Directed bench for hamming_scrub_decoder: vector table, backpressure, reset flush,
// clear priority and counter saturation (second instance with a 2-bit counter).
module tb_hamming_scrub_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_sat;
  logic [15:0] in_data = '0;
  logic [11:0] in_parity = '0;
  logic        out_valid, out_valid_sat;
  logic        out_ready = 1'b1;
  logic [15:0] out_data, out_data_sat;
  logic [11:0] out_parity, out_parity_sat;
  logic [3:0]  out_err, out_err_sat;
  logic [11:0] out_syn, out_syn_sat;
  logic [15:0] err_count;
  logic [1:0]  err_count_sat;
  logic        err_sticky, err_sticky_sat;
  logic        clear = 1'b0;

  always #5 clk = ~clk;

  hamming_scrub_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_parity(out_parity),
    .out_err(out_err), .out_syn(out_syn), .err_count(err_count),
    .err_sticky(err_sticky), .clear(clear)
  );

  hamming_scrub_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sat),
    .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid_sat),
    .out_ready(out_ready), .out_data(out_data_sat), .out_parity(out_parity_sat),
    .out_err(out_err_sat), .out_syn(out_syn_sat), .err_count(err_count_sat),
    .err_sticky(err_sticky_sat), .clear(clear)
  );

  typedef struct {
    logic [15:0] d;
    logic [11:0] p;
    logic [15:0] ed;
    logic [11:0] ep;
    logic [3:0]  ee;
    logic [11:0] es;
  } vec_t;

  vec_t vt[10];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic int pop4(input logic [3:0] e);
    return int'(e[0]) + int'(e[1]) + int'(e[2]) + int'(e[3]);
  endfunction

  task automatic check_stats(input string tag);
    int sat;
    sat = (exp_cnt > 3) ? 3 : exp_cnt;
    check({tag, "_cnt"},     32'(err_count), 32'(exp_cnt));
    check({tag, "_sticky"},  32'(err_sticky), 32'(exp_cnt > 0));
    check({tag, "_cnt_sat"}, 32'(err_count_sat), 32'(sat));
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, "_valid"},  32'(out_valid), 32'd1);
    check({tag, "_data"},   32'(out_data), 32'(v.ed));
    check({tag, "_parity"}, 32'(out_parity), 32'(v.ep));
    check({tag, "_err"},    32'(out_err), 32'(v.ee));
    check({tag, "_syn"},    32'(out_syn), 32'(v.es));
  endtask

  // One isolated word with out_ready=1: present, two edges to the output, one edge to retire.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    in_valid = 1'b1; in_data = v.d; in_parity = v.p;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_out(tag, v);
    @(posedge clk);
    exp_cnt += pop4(v.ee);
    @(negedge clk);
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
    check_stats(tag);
  endtask

  initial begin
    vt[0] = '{16'h811A, 12'hEDA, 16'h811A, 12'hEDA, 4'b0000, 12'h000};
    vt[1] = '{16'h8118, 12'hEDA, 16'h811A, 12'hEDA, 4'b0001, 12'h005};
    vt[2] = '{16'h811A, 12'hEDB, 16'h811A, 12'hEDA, 4'b0001, 12'h001};
    vt[3] = '{16'h9038, 12'hEDA, 16'h811A, 12'hEDA, 4'b1111, 12'h6ED};
    vt[4] = '{16'h811A, 12'h6DA, 16'h811A, 12'hEDA, 4'b1000, 12'h800};
    vt[5] = '{16'h891A, 12'hEDA, 16'h811A, 12'hEDA, 4'b0100, 12'h1C0};
    vt[6] = '{16'hFFFF, 12'hFFF, 16'hFFFF, 12'hFFF, 4'b0000, 12'h000};
    vt[7] = '{16'hFFFE, 12'hFFF, 16'hFFFF, 12'hFFF, 4'b0001, 12'h003};
    vt[8] = '{16'h0000, 12'h000, 16'h0000, 12'h000, 4'b0000, 12'h000};
    vt[9] = '{16'h0000, 12'h002, 16'h0000, 12'h000, 4'b0001, 12'h002};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_data",  32'(out_data), 32'd0);
    check("rst_out_par",   32'(out_parity), 32'd0);
    check_stats("rst");

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i]);
    end

    // Backpressure: 5 words, out_ready low for the first 4 cycles
    begin
      int acc = 0;
      int got = 0;
      logic held_v = 1'b0;
      logic [15:0] held_d = '0;
      logic accept;
      for (int c = 0; c < 40 && got < 5; c++) begin
        @(negedge clk);
        out_ready = (c >= 4);
        in_valid  = (acc < 5);
        in_data   = (acc < 5) ? vt[acc].d : 16'h0;
        in_parity = (acc < 5) ? vt[acc].p : 12'h0;
        #1;
        if (held_v && out_valid)
          check($sformatf("bp_stable_c%0d", c), 32'(out_data), 32'(held_d));
        held_v = out_valid && !out_ready;
        held_d = out_data;
        if (out_valid && out_ready) begin
          check_out($sformatf("bp_out%0d", got), vt[got]);
          exp_cnt += pop4(vt[got].ee);
          got++;
        end
        if (c == 2 || c == 3)
          check($sformatf("bp_in_ready_low_c%0d", c), 32'(in_ready), 32'd0);
        if (c == 3)
          check("bp_accepts_stalled", 32'(acc), 32'd2);
        accept = in_valid && in_ready;
        @(posedge clk);
        if (accept) acc++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_all_out", 32'(got), 32'd5);
      check("bp_drained", 32'(out_valid), 32'd0);
      check_stats("bp");
    end

    // Reset with both stages full flushes immediately
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = vt[3].d; in_parity = vt[3].p;
    @(posedge clk);
    @(negedge clk);
    in_data = vt[1].d; in_parity = vt[1].p;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready",  32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    exp_cnt = 0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_data",  32'(out_data), 32'd0);
    check_stats("flush");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_stays_empty", 32'(out_valid), 32'd0);

    // Clear wins over a same-cycle erroring handshake
    run_vec("pre_clear", vt[1]);
    @(negedge clk);
    in_valid = 1'b1; in_data = vt[3].d; in_parity = vt[3].p;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("clr_out_valid", 32'(out_valid), 32'd1);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    exp_cnt = 0;
    check_stats("clear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
